perm_cmd_scheduler: RTL

PERM_CMD_SCHEDULER -- requirements
Module: perm_cmd_scheduler

---
 rtl/perm_cmd_scheduler_pkg.sv | 28 ++
 rtl/perm_cmd_scheduler_fifo.sv | 53 +++++
 rtl/perm_cmd_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/perm_cmd_scheduler_pkg.sv
// Shared types and constants for the permutation command scheduler.
// The tag field is sized for the widest supported TAGW; narrower tags are zero-extended.
package FHE_ALU_PKG;

    localparam int unsigned logN             = 16;
    localparam int unsigned logE             = 4;
    localparam int unsigned MIDMAX           = logN - 2 * logE;
    localparam int unsigned PERM_ARM_TIMEOUT = 4;
    localparam int unsigned PERM_TAG_MAXW    = 16;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_LAUNCH,
        PS_ARM,
        PS_RUN,
        PS_DONE
    } perm_state_e;

    typedef struct packed {
        logic                     op;
        logic [logN-logE-1:0]     base;
        logic [logE-1:0]          barrel_store;
        logic [logE-1:0]          barrel_load;
        logic [logE-1:0]          diff_logN;
        logic [PERM_TAG_MAXW-1:0] tag;
    } PermCmd;

endpackage

// File: rtl/perm_cmd_scheduler_fifo.sv
// DEPTH-entry FIFO of PermCmd; head entry is read straight from the storage registers.
module perm_cmd_fifo
    import FHE_ALU_PKG::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   push_i,
    input  PermCmd data_i,
    input  logic   pop_i,
    output PermCmd data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    PermCmd          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/perm_cmd_scheduler.sv
// Queues permutation commands and launches them one at a time on the permutation engine,
// watching its busy flag to report completion or a launch that never started.
module perm_cmd_scheduler
    import FHE_ALU_PKG::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [logN-logE-1:0] cmd_transpose_base,
    input  logic [logE-1:0]      cmd_barrel_store,
    input  logic [logE-1:0]      cmd_barrel_load,
    input  logic [logE-1:0]      cmd_diff_logN,
    input  logic [TAGW-1:0]      cmd_tag,
    output logic                 start_bitRev,
    output logic                 start_transpose,
    output logic [logN-logE-1:0] transpose_base,
    output logic [logE-1:0]      barrel_store,
    output logic [logE-1:0]      barrel_load,
    output logic [logE-1:0]      diff_logN,
    input  logic                 bitRev_working,
    output logic                 done_valid,
    output logic [TAGW-1:0]      done_tag,
    output logic                 cmd_err,
    output logic                 busy
);

    PermCmd               cmd_in;
    PermCmd               head;
    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 cmd_ok;
    logic                 push;
    logic                 pop;
    logic                 arm_timeout;

    perm_state_e          state_q, state_d;
    logic [2:0]           tmr_q;
    logic                 op_q;
    logic [TAGW-1:0]      tag_q;
    logic [logN-logE-1:0] base_q;
    logic [logE-1:0]      bs_q;
    logic [logE-1:0]      bl_q;
    logic [logE-1:0]      diff_q;
    logic                 err_q;

    always_comb begin
        cmd_in              = '0;
        cmd_in.op           = cmd_op;
        cmd_in.base         = cmd_transpose_base;
        cmd_in.barrel_store = cmd_barrel_store;
        cmd_in.barrel_load  = cmd_barrel_load;
        cmd_in.diff_logN    = cmd_diff_logN;
        cmd_in.tag          = PERM_TAG_MAXW'(cmd_tag);
    end

    // Out-of-range commands complete the handshake but are dropped and flagged.
    assign accept = cmd_valid && !full;
    assign cmd_ok = (cmd_diff_logN <= logE'(MIDMAX));
    assign push   = accept && cmd_ok;

    perm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .data_i  (cmd_in),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    if (TAGW < PERM_TAG_MAXW) begin : g_tag_pad
        logic unused_tag_hi;
        assign unused_tag_hi = |head.tag[PERM_TAG_MAXW-1:TAGW];
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        arm_timeout = 1'b0;
        case (state_q)
            PS_IDLE: begin
                if (!empty && !bitRev_working) begin
                    pop     = 1'b1;
                    state_d = PS_LAUNCH;
                end
            end
            PS_LAUNCH: state_d = PS_ARM;
            PS_ARM: begin
                if (bitRev_working) begin
                    state_d = PS_RUN;
                end else if (tmr_q == 3'(PERM_ARM_TIMEOUT - 1)) begin
                    arm_timeout = 1'b1;
                    state_d     = PS_DONE;
                end
            end
            PS_RUN: begin
                if (!bitRev_working) state_d = PS_DONE;
            end
            PS_DONE: state_d = PS_IDLE;
            default: state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= PS_IDLE;
            tmr_q   <= '0;
            op_q    <= 1'b0;
            tag_q   <= '0;
            base_q  <= '0;
            bs_q    <= '0;
            bl_q    <= '0;
            diff_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= arm_timeout || (accept && !cmd_ok);
            if (state_q == PS_LAUNCH)   tmr_q <= '0;
            else if (state_q == PS_ARM) tmr_q <= tmr_q + 3'd1;
            if (pop) begin
                op_q   <= head.op;
                tag_q  <= head.tag[TAGW-1:0];
                base_q <= head.base;
                bs_q   <= head.barrel_store;
                bl_q   <= head.barrel_load;
                diff_q <= head.diff_logN;
            end
        end
    end

    assign cmd_ready       = !full;
    assign busy            = !empty || (state_q != PS_IDLE);
    assign start_bitRev    = (state_q == PS_LAUNCH) && !op_q;
    assign start_transpose = (state_q == PS_LAUNCH) && op_q;
    assign done_valid      = (state_q == PS_DONE);
    assign done_tag        = tag_q;
    assign cmd_err         = err_q;
    assign transpose_base  = base_q;
    assign barrel_store    = bs_q;
    assign barrel_load     = bl_q;
    assign diff_logN       = diff_q;

endmodule
